fb_pingpong_writer: RTL and testbench



---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_bank_ram.sv | 28 ++
 rtl/fb_pingpong_writer.sv | 158 +++++++++++++++
 tb/tb_fb_pingpong_writer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, write-state encoding and helpers
// for the ping-pong frame buffer (fb_bank_ram, fb_pingpong_writer).
package fb_pkg;

   localparam int FB_WIDTH  = 160;
   localparam int FB_HEIGHT = 120;
   localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
   localparam int FB_ADDR_W = 15;
   localparam int FB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2,
      HOLD  = 2'd3
   } wr_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// fb_bank_ram: one frame bank, single write port, registered read port.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (1-cycle).
module fb_bank_ram
   import fb_pkg::*;
#(
   parameter int DEPTH  = FB_PIXELS,
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // No reset on the array or read register so this maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/fb_pingpong_writer.sv
// fb_pingpong_writer: double-buffered frame store; camera raster in,
// FBAddr->FBData reads from the completed bank; swap on frameReady/frameAck.
module fb_pingpong_writer
   import fb_pkg::*;
#(
   parameter int WIDTH  = FB_WIDTH,
   parameter int HEIGHT = FB_HEIGHT,
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W
) (
   input  logic              clock,
   input  logic              nReset,
   input  logic              frameStart,
   input  logic              pixValid,
   input  logic [DATA_W-1:0] pixData,
   input  logic [ADDR_W-1:0] FBAddr,
   output logic [DATA_W-1:0] FBData,
   output logic              frameReady,
   input  logic              frameAck,
   output logic [7:0]        dropCount,
   output logic [7:0]        shortCount
);

   localparam int PIXELS = WIDTH * HEIGHT;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(PIXELS - 1);
   localparam logic [ADDR_W-1:0] PIX_A = ADDR_W'(PIXELS);

   wr_state_e         state_q, state_d;
   logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
   logic              wrBank_q, wrBank_d;
   logic              ready_q, ready_d;
   logic [7:0]        drop_q, drop_d;
   logic [7:0]        short_q, short_d;
   logic              rdOk_q, rdSel_q;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic              startPix;
   logic [DATA_W-1:0] rd0, rd1;

   assign startPix = frameStart & pixValid;

   always_comb begin
      state_d  = state_q;
      wrAddr_d = wrAddr_q;
      wrBank_d = wrBank_q;
      drop_d   = drop_q;
      short_d  = short_q;
      we       = 1'b0;
      waddr    = wrAddr_q;
      // Ack only clears a presented frame; a swap below never
      // coincides with it because swaps need ready_q low.
      ready_d  = ready_q & ~frameAck;
      unique case (state_q)
         IDLE: begin
            if (startPix) begin
               we       = 1'b1;
               waddr    = '0;
               wrAddr_d = ADDR_W'(1);
               state_d  = WRITE;
            end
         end
         WRITE: begin
            if (startPix) begin
               we       = 1'b1;
               waddr    = '0;
               wrAddr_d = ADDR_W'(1);
               short_d  = sat_inc8(short_q);
            end else if (pixValid) begin
               we       = 1'b1;
               wrAddr_d = wrAddr_q + ADDR_W'(1);
               if (wrAddr_q == LAST) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            wrAddr_d = '0;
            if (!ready_q) begin
               wrBank_d = ~wrBank_q;
               ready_d  = 1'b1;
               state_d  = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (startPix) begin
               drop_d = sat_inc8(drop_q);
            end
            // Swap one cycle after ready reads low: reader sees
            // exactly one low cycle between frames.
            if (!ready_q) begin
               wrBank_d = ~wrBank_q;
               ready_d  = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!nReset) begin
         state_q  <= IDLE;
         wrAddr_q <= '0;
         wrBank_q <= 1'b0;
         ready_q  <= 1'b0;
         drop_q   <= '0;
         short_q  <= '0;
         rdOk_q   <= 1'b0;
         rdSel_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wrAddr_q <= wrAddr_d;
         wrBank_q <= wrBank_d;
         ready_q  <= ready_d;
         drop_q   <= drop_d;
         short_q  <= short_d;
         // Bank select captured with the address, so a read issued
         // in a swap cycle still returns the old bank.
         rdOk_q   <= (FBAddr < PIX_A);
         rdSel_q  <= ~wrBank_q;
      end
   end

   fb_bank_ram #(
      .DEPTH  (PIXELS),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bank0 (
      .clk_i   (clock),
      .we_i    (we & ~wrBank_q),
      .waddr_i (waddr),
      .wdata_i (pixData),
      .raddr_i (FBAddr),
      .rdata_o (rd0)
   );

   fb_bank_ram #(
      .DEPTH  (PIXELS),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bank1 (
      .clk_i   (clock),
      .we_i    (we & wrBank_q),
      .waddr_i (waddr),
      .wdata_i (pixData),
      .raddr_i (FBAddr),
      .rdata_o (rd1)
   );

   assign FBData     = rdOk_q ? (rdSel_q ? rd1 : rd0) : '0;
   assign frameReady = ready_q;
   assign dropCount  = drop_q;
   assign shortCount = short_q;

endmodule

// File: tb/tb_fb_pingpong_writer.sv
// tb_fb_pingpong_writer: scoreboard bench; frames are seeded pixel
// functions, reads are predicted from which frame should be visible.
module tb_fb_pingpong_writer;

   localparam int NPIX = 160 * 120;

   logic        clock;
   logic        nReset;
   logic        frameStart;
   logic        pixValid;
   logic [7:0]  pixData;
   logic [14:0] FBAddr;
   logic [7:0]  FBData;
   logic        frameReady;
   logic        frameAck;
   logic [7:0]  dropCount;
   logic [7:0]  shortCount;

   int errors = 0;
   int checks = 0;

   int exp_q[$];
   int adr_q[$];
   logic rd_req = 1'b0;
   logic rdv_d  = 1'b0;
   logic rdy_prev = 1'b0;
   int   rises = 0;

   fb_pingpong_writer dut (
      .clock      (clock),
      .nReset     (nReset),
      .frameStart (frameStart),
      .pixValid   (pixValid),
      .pixData    (pixData),
      .FBAddr     (FBAddr),
      .FBData     (FBData),
      .frameReady (frameReady),
      .frameAck   (frameAck),
      .dropCount  (dropCount),
      .shortCount (shortCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Frame content: seed 0 gives pixData = addr[7:0].
   function automatic int pix(input int unsigned s, input int a);
      int unsigned v;
      v = int'(a) * (2 * s + 1) + s + (int'(a) >> 7) * s;
      return int'(v[7:0]);
   endfunction

   // Reference read: visible frame seed, zero outside the frame.
   function automatic int ref_rd(input int unsigned s, input int a);
      if (a >= NPIX) return 0;
      return pix(s, a);
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic stream(input int unsigned s, input int n, input bit stall);
      for (int a = 0; a < n; a++) begin
         if (stall) begin
            while ($urandom_range(2) == 0) begin
               pixValid   = 1'b0;
               frameStart = 1'($urandom_range(1));
               pixData    = 8'($urandom);
               cyc();
            end
         end
         frameStart = (a == 0);
         pixValid   = 1'b1;
         pixData    = 8'(pix(s, a));
         cyc();
      end
      pixValid   = 1'b0;
      frameStart = 1'b0;
   endtask

   task automatic do_read(input int a, input int e);
      FBAddr = 15'(a);
      rd_req = 1'b1;
      exp_q.push_back(e);
      adr_q.push_back(a);
      cyc();
      rd_req = 1'b0;
   endtask

   task automatic read_sample(input int unsigned s, input int n);
      int a;
      for (int i = 0; i < n; i++) begin
         a = ($urandom_range(7) == 0) ? $urandom_range(32767)
                                      : $urandom_range(NPIX - 1);
         do_read(a, ref_rd(s, a));
      end
   endtask

   // Monitor: FBData is due one edge after the read was sampled.
   always @(posedge clock) rdv_d <= rd_req;

   always @(negedge clock) begin
      int e, a;
      if (frameReady && !rdy_prev) rises++;
      rdy_prev <= frameReady;
      if (rdv_d) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_underflow: got %0d expected none", FBData);
         end else begin
            e = exp_q.pop_front();
            a = adr_q.pop_front();
            if (int'(FBData) !== e) begin
               errors++;
               $display("FAIL rd[%0d]: got %0d expected %0d", a, FBData, e);
            end
         end
      end
   end

   initial begin
      int unsigned s2, s3, s4p, s4;
      int a;
      nReset = 1'b0; frameStart = 1'b0; pixValid = 1'b0;
      pixData = '0; FBAddr = '0; frameAck = 1'b0;
      cyc(); cyc();
      chk("rst_ready", frameReady, 0);
      chk("rst_data", FBData, 0);
      chk("rst_drop", dropCount, 0);
      chk("rst_short", shortCount, 0);
      nReset = 1'b1;
      cyc();

      // Ack with nothing presented
      frameAck = 1'b1; cyc(); frameAck = 1'b0; cyc();
      chk("ack_idle_ready", frameReady, 0);

      // F1: full frame, no stalls, pattern = addr[7:0]
      stream(0, NPIX, 1'b0);
      chk("f1_ready_t1", frameReady, 0);
      cyc();
      chk("f1_ready_t2", frameReady, 1);
      do_read(161, 8'hA1);
      do_read(NPIX - 1, 8'hFF);
      do_read(NPIX, 0);
      do_read(32767, 0);
      read_sample(0, 100);

      // F2: random stalls, completes into HOLD while F1 presented
      s2 = $urandom | 32'h1;
      stream(s2, NPIX, 1'b1);
      cyc(); cyc(); cyc();
      chk("hold_ready", frameReady, 1);
      read_sample(0, 50);

      // F3 start while holding: dropped
      stream(s2 ^ 32'h33, 5, 1'b0);
      cyc();
      chk("hold_drop", dropCount, 1);
      chk("hold_ready2", frameReady, 1);

      // Ack: one low cycle, read in swap cycle sees old bank
      do a = $urandom_range(NPIX - 1);
      while (pix(0, a) == pix(s2, a));
      frameAck = 1'b1; cyc(); frameAck = 1'b0;
      chk("ack_low", frameReady, 0);
      do_read(a, ref_rd(0, a));
      chk("ack_high", frameReady, 1);
      do_read(a, ref_rd(s2, a));
      read_sample(s2, 150);
      chk("drop_kept", dropCount, 1);

      // Reset mid-frame at pixel 9000
      s3 = $urandom;
      stream(s3, 9000, 1'b0);
      do a = $urandom_range(NPIX - 1);
      while (pix(s2, a) == 0);
      FBAddr = 15'(a);
      cyc(); cyc();
      chk("pre_rst_data", FBData, pix(s2, a));
      nReset = 1'b0; cyc(); nReset = 1'b1;
      chk("mid_rst_ready", frameReady, 0);
      chk("mid_rst_data", FBData, 0);
      chk("mid_rst_drop", dropCount, 0);
      chk("mid_rst_short", shortCount, 0);

      // Ack while not ready: no swap, F2 bank still visible
      frameAck = 1'b1; cyc(); frameAck = 1'b0; cyc();
      chk("ack_norm_ready", frameReady, 0);
      read_sample(s2, 20);

      // Short frame then full restart
      s4p = $urandom;
      s4  = s4p ^ 32'h1;
      stream(s4p, 500, 1'b0);
      stream(s4, NPIX, 1'b0);
      chk("short_cnt", shortCount, 1);
      chk("f4_ready_t1", frameReady, 0);
      cyc();
      chk("f4_ready_t2", frameReady, 1);
      do_read(0, pix(s4, 0));
      do_read(NPIX - 1, pix(s4, NPIX - 1));
      read_sample(s4, 100);

      cyc(); cyc(); cyc();
      chk("rises", rises, 3);
      chk("sb_drain", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
